ucb_stack_ra: RTL and testbench

- Parametrised successor to the unsatisfied-clause buffer in the WSAT solver core.
- Stores clause entries in an internally inferred synchronous single-port RAM and tracks occupancy internally.
- Supports four operations: append, pop-top, random-index read (for random clause pick) and O(1) delete-by-index using swap-with-last (for removing clauses that become satisfied).
- Sits between the clause evaluator (push/delete) and the flip-selection logic (read/pop).

---
 rtl/ucb_stack_ra.sv | 206 ++++++++++++++++++++
 tb/tb_ucb_stack_ra.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucb_stack_ra.sv
// Unsatisfied-clause buffer with stack semantics and random access.
// Entries live in an inferred synchronous single-port RAM; occupancy is tracked in count_q.
// Operations: READ (random index), PUSH (append), POP (remove top) and DELETE (O(1)
// removal by index, filling the hole with the last entry).
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   load_i, count_init_i   preload occupancy (idle only, saturates at DEPTH)
//   op_valid_i/op_ready_o  operation handshake
//   op_code_i              00 READ, 01 PUSH, 10 POP, 11 DELETE
//   op_index_i, op_data_i  index for READ/DELETE, entry for PUSH
//   rd_valid_o, rd_data_o  read result pulse; rd_data_o holds between pulses
//   count_o, empty_o, full_o                       occupancy status
//   err_overflow_o, err_underflow_o, err_index_o   sticky errors
//   err_clear_i                                    clears the sticky errors
module ucb_stack_ra #(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W:0]   count_init_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [1:0]        op_code_i,
  input  logic [ADDR_W-1:0] op_index_i,
  input  logic [DATA_W-1:0] op_data_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              err_overflow_o,
  output logic              err_underflow_o,
  output logic              err_index_o,
  input  logic              err_clear_i
);

  localparam logic [ADDR_W:0] DepthCnt = DEPTH[ADDR_W:0];

  localparam logic [1:0] OpRead   = 2'b00;
  localparam logic [1:0] OpPush   = 2'b01;
  localparam logic [1:0] OpPop    = 2'b10;
  localparam logic [1:0] OpDelete = 2'b11;

  typedef enum logic [1:0] {StIdle, StDelFetch, StDelWrite} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] del_idx_q, del_idx_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_hold_q;
  logic              ovf_q, unf_q, idx_q;
  logic              ovf_set, unf_set, idx_set;

  // RAM port controls
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   count_m1;
  logic [ADDR_W:0]   idx_ext;
  logic [ADDR_W:0]   load_val;
  logic              idx_in_range, idx_is_last;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == DepthCnt);
  assign count_o    = count_q;
  assign op_ready_o = (state_q == StIdle) && !load_i;

  assign count_m1     = count_q - 1'b1;
  assign idx_ext      = {1'b0, op_index_i};
  assign idx_in_range = (idx_ext < count_q);
  assign idx_is_last  = (idx_ext == count_m1);
  assign load_val     = (count_init_i > DepthCnt) ? DepthCnt : count_init_i;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    del_idx_d  = del_idx_q;
    rd_valid_d = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = op_data_i;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    idx_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          count_d = load_val;
        end else if (op_valid_i) begin
          unique case (op_code_i)
            OpRead: begin
              if (idx_in_range) begin
                ram_en     = 1'b1;
                ram_addr   = op_index_i;
                rd_valid_d = 1'b1;
              end else begin
                idx_set = 1'b1;
              end
            end
            OpPush: begin
              if (full_o) begin
                ovf_set = 1'b1;
              end else begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = count_q[ADDR_W-1:0];
                count_d  = count_q + 1'b1;
              end
            end
            OpPop: begin
              if (empty_o) begin
                unf_set = 1'b1;
              end else begin
                ram_en     = 1'b1;
                ram_addr   = count_m1[ADDR_W-1:0];
                rd_valid_d = 1'b1;
                count_d    = count_m1;
              end
            end
            OpDelete: begin
              if (empty_o) begin
                unf_set = 1'b1;
              end else if (!idx_in_range) begin
                idx_set = 1'b1;
              end else if (idx_is_last) begin
                count_d = count_m1;
              end else begin
                del_idx_d = op_index_i;
                state_d   = StDelFetch;
              end
            end
            default: ;
          endcase
        end
      end
      StDelFetch: begin
        // Fetch the last entry; it moves into the hole left by the deleted one.
        ram_en   = 1'b1;
        ram_addr = count_m1[ADDR_W-1:0];
        state_d  = StDelWrite;
      end
      StDelWrite: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = del_idx_q;
        ram_wdata = ram_rdata_q;
        count_d   = count_m1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
      end else begin
        ram_rdata_q <= mem[ram_addr];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      count_q    <= '0;
      del_idx_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      idx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      del_idx_q  <= del_idx_d;
      rd_valid_q <= rd_valid_d;
      if (rd_valid_q) begin
        rd_hold_q <= ram_rdata_q;
      end
      // A new error in the same cycle as err_clear keeps the flag set.
      ovf_q <= (ovf_q && !err_clear_i) || ovf_set;
      unf_q <= (unf_q && !err_clear_i) || unf_set;
      idx_q <= (idx_q && !err_clear_i) || idx_set;
    end
  end

  // The RAM output register is also used by the delete fetch, so the last returned
  // entry is kept separately to hold rd_data_o steady between read pulses.
  assign rd_valid_o      = rd_valid_q;
  assign rd_data_o       = rd_valid_q ? ram_rdata_q : rd_hold_q;
  assign err_overflow_o  = ovf_q;
  assign err_underflow_o = unf_q;
  assign err_index_o     = idx_q;

endmodule

// File: tb/tb_ucb_stack_ra.sv
module tb_ucb_stack_ra;
  localparam int unsigned DW     = 36;
  localparam int unsigned BigD   = 2048;
  localparam int unsigned SmallD = 4;
  localparam logic [1:0] CRead = 2'b00, CPush = 2'b01, CPop = 2'b10, CDel = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Stimulus per DUT: index 0 = DEPTH 2048, index 1 = DEPTH 4.
  logic          load  [2];
  logic [11:0]   cinit [2];
  logic          vld   [2];
  logic [1:0]    code  [2];
  logic [10:0]   idx   [2];
  logic [DW-1:0] data  [2];
  logic          eclr  [2];

  logic          rdy [2], rdv [2], emp [2], ful [2], eovf [2], eunf [2], eidx [2];
  logic [DW-1:0] rdd [2];
  logic [11:0]   cnt_big;
  logic [2:0]    cnt_small;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  ucb_stack_ra #(.DATA_W(DW), .DEPTH(BigD)) u_big (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load[0]), .count_init_i(cinit[0]),
    .op_valid_i(vld[0]), .op_ready_o(rdy[0]), .op_code_i(code[0]), .op_index_i(idx[0]),
    .op_data_i(data[0]), .rd_valid_o(rdv[0]), .rd_data_o(rdd[0]), .count_o(cnt_big),
    .empty_o(emp[0]), .full_o(ful[0]), .err_overflow_o(eovf[0]), .err_underflow_o(eunf[0]),
    .err_index_o(eidx[0]), .err_clear_i(eclr[0])
  );

  ucb_stack_ra #(.DATA_W(DW), .DEPTH(SmallD)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load[1]), .count_init_i(cinit[1][2:0]),
    .op_valid_i(vld[1]), .op_ready_o(rdy[1]), .op_code_i(code[1]), .op_index_i(idx[1][1:0]),
    .op_data_i(data[1]), .rd_valid_o(rdv[1]), .rd_data_o(rdd[1]), .count_o(cnt_small),
    .empty_o(emp[1]), .full_o(ful[1]), .err_overflow_o(eovf[1]), .err_underflow_o(eunf[1]),
    .err_index_o(eidx[1]), .err_clear_i(eclr[1])
  );

  // Behavioural model: an array plus an occupancy number; a long delete is a
  // two-cycle busy window after which the hole is filled with the last entry.
  int unsigned   m_depth [2];
  int unsigned   m_cnt   [2];
  int unsigned   m_busy  [2];
  int unsigned   m_del   [2];
  logic [DW-1:0] m_mem   [2][BigD];
  logic          m_eovf [2], m_eunf [2], m_eidx [2], m_rdv [2];
  logic [DW-1:0] m_rdd  [2];

  task automatic model_reset(input int d);
    m_cnt[d]  = 0;
    m_busy[d] = 0;
    m_eovf[d] = 1'b0;
    m_eunf[d] = 1'b0;
    m_eidx[d] = 1'b0;
    m_rdv[d]  = 1'b0;
    m_rdd[d]  = '0;
  endtask

  task automatic model_step(input int d);
    logic n_ovf, n_unf, n_idx, rv;
    int unsigned ix;
    n_ovf = 1'b0; n_unf = 1'b0; n_idx = 1'b0; rv = 1'b0;
    ix = int'(idx[d]);
    if (m_busy[d] != 0) begin
      m_busy[d]--;
      if (m_busy[d] == 0) begin
        m_mem[d][m_del[d]] = m_mem[d][m_cnt[d] - 1];
        m_cnt[d]--;
      end
    end else if (load[d]) begin
      m_cnt[d] = (int'(cinit[d]) > m_depth[d]) ? m_depth[d] : int'(cinit[d]);
    end else if (vld[d]) begin
      case (code[d])
        CRead: if (ix < m_cnt[d]) begin rv = 1'b1; m_rdd[d] = m_mem[d][ix]; end
               else n_idx = 1'b1;
        CPush: if (m_cnt[d] == m_depth[d]) n_ovf = 1'b1;
               else begin m_mem[d][m_cnt[d]] = data[d]; m_cnt[d]++; end
        CPop:  if (m_cnt[d] == 0) n_unf = 1'b1;
               else begin rv = 1'b1; m_cnt[d]--; m_rdd[d] = m_mem[d][m_cnt[d]]; end
        default: begin
          if (m_cnt[d] == 0) n_unf = 1'b1;
          else if (ix >= m_cnt[d]) n_idx = 1'b1;
          else if (ix == m_cnt[d] - 1) m_cnt[d]--;
          else begin m_busy[d] = 2; m_del[d] = ix; end
        end
      endcase
    end
    m_eovf[d] = (m_eovf[d] && !eclr[d]) || n_ovf;
    m_eunf[d] = (m_eunf[d] && !eclr[d]) || n_unf;
    m_eidx[d] = (m_eidx[d] && !eclr[d]) || n_idx;
    m_rdv[d]  = rv;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) model_reset(d);
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] get_cnt(input int d);
    return (d == 0) ? cnt_big : {9'd0, cnt_small};
  endfunction

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d_count", d), 64'(get_cnt(d)), 64'(m_cnt[d]));
        chk($sformatf("d%0d_empty", d), 64'(emp[d]), 64'(m_cnt[d] == 0));
        chk($sformatf("d%0d_full", d), 64'(ful[d]), 64'(m_cnt[d] == m_depth[d]));
        chk($sformatf("d%0d_ready", d), 64'(rdy[d]), 64'(m_busy[d] == 0 && !load[d]));
        chk($sformatf("d%0d_rd_valid", d), 64'(rdv[d]), 64'(m_rdv[d]));
        chk($sformatf("d%0d_rd_data", d), 64'(rdd[d]), 64'(m_rdd[d]));
        chk($sformatf("d%0d_err_ovf", d), 64'(eovf[d]), 64'(m_eovf[d]));
        chk($sformatf("d%0d_err_unf", d), 64'(eunf[d]), 64'(m_eunf[d]));
        chk($sformatf("d%0d_err_idx", d), 64'(eidx[d]), 64'(m_eidx[d]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int d, input logic [1:0] c, input int unsigned ix,
                    input logic [DW-1:0] dat);
    vld[d]  = 1'b1;
    code[d] = c;
    idx[d]  = ix[10:0];
    data[d] = dat;
    cyc();
    vld[d] = 1'b0;
  endtask

  task automatic do_load(input int d, input logic [11:0] v);
    load[d]  = 1'b1;
    cinit[d] = v;
    #1;
    chk("load_ready_low", 64'(rdy[d]), 64'd0);
    cyc();
    load[d] = 1'b0;
  endtask

  initial begin
    m_depth[0] = BigD;
    m_depth[1] = SmallD;
    for (int d = 0; d < 2; d++) begin
      load[d] = 1'b0; cinit[d] = '0; vld[d] = 1'b0; code[d] = '0;
      idx[d] = '0; data[d] = '0; eclr[d] = 1'b0;
      model_reset(d);
    end
    rst_n = 1'b0;
    repeat (3) cyc();
    chk_en = 1'b1;
    rst_n = 1'b1;
    chk("reset_count", 64'(cnt_big), 64'd0);
    chk("reset_ready", 64'(rdy[0]), 64'd1);
    chk("reset_empty", 64'(emp[0]), 64'd1);
    chk("reset_rd_data", 64'(rdd[0]), 64'd0);

    // Push A,B,C then random reads
    op(0, CPush, 0, 36'hA);
    op(0, CPush, 0, 36'hB);
    op(0, CPush, 0, 36'hC);
    chk("push3_count", 64'(cnt_big), 64'd3);
    op(0, CRead, 1, '0);
    chk("read1_valid", 64'(rdv[0]), 64'd1);
    chk("read1_data", 64'(rdd[0]), 64'hB);
    op(0, CRead, 3, '0);
    chk("read3_err_idx", 64'(eidx[0]), 64'd1);
    chk("read3_no_valid", 64'(rdv[0]), 64'd0);
    chk("read3_data_held", 64'(rdd[0]), 64'hB);
    eclr[0] = 1'b1; cyc(); eclr[0] = 1'b0;
    chk("clear_err_idx", 64'(eidx[0]), 64'd0);

    // {A,B,C,D}: delete idx1 (swap with last); a push held during the busy window is ignored
    op(0, CPush, 0, 36'hD);
    op(0, CDel, 1, '0);
    chk("del_busy1", 64'(rdy[0]), 64'd0);
    vld[0] = 1'b1; code[0] = CPush; data[0] = 36'hEE;
    cyc();
    chk("del_busy2", 64'(rdy[0]), 64'd0);
    cyc();
    vld[0] = 1'b0;
    chk("del_done_ready", 64'(rdy[0]), 64'd1);
    chk("del_done_count", 64'(cnt_big), 64'd3);
    op(0, CRead, 0, '0); chk("after_del_r0", 64'(rdd[0]), 64'hA);
    op(0, CRead, 1, '0); chk("after_del_r1", 64'(rdd[0]), 64'hD);
    op(0, CRead, 2, '0); chk("after_del_r2", 64'(rdd[0]), 64'hC);
    op(0, CDel, 2, '0);
    chk("del_last_ready", 64'(rdy[0]), 64'd1);
    chk("del_last_count", 64'(cnt_big), 64'd2);

    // Pops down to underflow; error set wins over a simultaneous clear
    op(0, CPop, 0, '0);
    chk("pop1_data", 64'(rdd[0]), 64'hD);
    chk("pop1_count", 64'(cnt_big), 64'd1);
    op(0, CPop, 0, '0);
    chk("pop2_data", 64'(rdd[0]), 64'hA);
    chk("pop2_empty", 64'(emp[0]), 64'd1);
    op(0, CPop, 0, '0);
    chk("pop3_unf", 64'(eunf[0]), 64'd1);
    chk("pop3_count", 64'(cnt_big), 64'd0);
    eclr[0] = 1'b1;
    op(0, CDel, 0, '0);
    eclr[0] = 1'b0;
    chk("clear_vs_set", 64'(eunf[0]), 64'd1);
    chk("del_empty_no_idx", 64'(eidx[0]), 64'd0);
    eclr[0] = 1'b1; cyc(); eclr[0] = 1'b0;
    chk("clear_unf", 64'(eunf[0]), 64'd0);

    // Preload occupancy, including saturation
    do_load(0, 12'd5);
    chk("load5_count", 64'(cnt_big), 64'd5);
    do_load(0, 12'hFFF);
    chk("load_sat_count", 64'(cnt_big), 64'd2048);
    chk("load_sat_full", 64'(ful[0]), 64'd1);
    op(0, CPush, 0, 36'h1);
    chk("big_ovf", 64'(eovf[0]), 64'd1);
    eclr[0] = 1'b1; cyc(); eclr[0] = 1'b0;
    do_load(0, 12'd0);

    // Small build: fill, overflow, delete
    for (int i = 1; i <= 4; i++) op(1, CPush, 0, 36'(i));
    chk("small_full", 64'(ful[1]), 64'd1);
    op(1, CPush, 0, 36'h5);
    chk("small_ovf", 64'(eovf[1]), 64'd1);
    chk("small_ovf_count", 64'(cnt_small), 64'd4);
    op(1, CRead, 3, '0);
    chk("small_mem_kept", 64'(rdd[1]), 64'h4);
    eclr[1] = 1'b1; cyc(); eclr[1] = 1'b0;
    chk("small_clear", 64'({eovf[1], eunf[1], eidx[1]}), 64'd0);
    op(1, CDel, 0, '0);
    cyc(); cyc();
    op(1, CRead, 0, '0);
    chk("small_swap", 64'(rdd[1]), 64'h4);
    op(1, CRead, 3, '0);
    chk("small_idx_eq_count", 64'(eidx[1]), 64'd1);

    // Reset in the middle of a long delete
    op(0, CPush, 0, 36'h11);
    op(0, CPush, 0, 36'h22);
    op(0, CPush, 0, 36'h33);
    op(0, CDel, 0, '0);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_count", 64'(cnt_big), 64'd0);
    chk("rst_mid_ready", 64'(rdy[0]), 64'd1);
    chk("rst_mid_rd_valid", 64'(rdv[0]), 64'd0);
    cyc();
    rst_n = 1'b1;
    op(0, CPush, 0, 36'h77);
    op(0, CRead, 0, '0);
    chk("post_rst_read", 64'(rdd[0]), 64'h77);
    cyc();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
